// File: rtl/rcreg_fifo.sv
// Two-entry receive FIFO between the RSR and the CPU-visible RCREG/RCIF/FERR/OERR registers.
// Latency: a frame pushed at edge N is visible on the registered outputs from edge N; a pop shows the next head at the same edge.
// Backpressure: none toward the RSR; a frame arriving while full (no same-cycle pop) is dropped and latches OERR. Define RCREG_NINTH_BIT_EN for 9-bit frames.
module rcreg_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_enable,
    input  logic        rsr_valid,
    input  logic [7:0]  rsr_data,
    input  logic        rsr_ferr,
`ifdef RCREG_NINTH_BIT_EN
    input  logic        rsr_rx9d,
`endif
    input  logic        read_enable,
    input  logic        clear_oerr,
    output logic [31:0] RCREG,
    output logic        RCIF,
    output logic        FERR,
    output logic        OERR,
    output logic [1:0]  rx_count
);

`ifdef RCREG_NINTH_BIT_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif

    typedef struct packed {
        logic          ferr;
        logic [DW-1:0] dat;
    } entry_t;

    entry_t      r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_oerr;
    logic [31:0] r_rcreg;
    logic        r_rcif;
    logic        r_ferr;

    entry_t      w_new;
    entry_t      w_head;
    logic        w_pop;
    logic        w_room;
    logic        w_frame;
    logic        w_push;
    logic        w_ovf;
    logic        w_wr_ptr_nxt;
    logic        w_rd_ptr_nxt;
    logic [1:0]  w_count_nxt;
    logic        w_oerr_nxt;

    always_comb begin
        w_new.ferr = rsr_ferr;
`ifdef RCREG_NINTH_BIT_EN
        w_new.dat  = {rsr_rx9d, rsr_data};
`else
        w_new.dat  = rsr_data;
`endif
    end

    // A pending overrun or a same-cycle clear both block capture of the incoming frame.
    assign w_pop   = rx_enable && read_enable && (r_count != 2'd0);
    assign w_room  = (r_count != 2'd2) || w_pop;
    assign w_frame = rx_enable && rsr_valid && !r_oerr && !clear_oerr;
    assign w_push  = w_frame && w_room;
    assign w_ovf   = w_frame && !w_room;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (!rx_enable) begin
            w_wr_ptr_nxt = 1'b0;
            w_rd_ptr_nxt = 1'b0;
            w_count_nxt  = 2'd0;
        end else begin
            if (w_push) w_wr_ptr_nxt = ~r_wr_ptr;
            if (w_pop)  w_rd_ptr_nxt = ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_comb begin
        w_oerr_nxt = r_oerr;
        if (!rx_enable || clear_oerr) begin
            w_oerr_nxt = 1'b0;
        end else if (w_ovf) begin
            w_oerr_nxt = 1'b1;
        end
    end

    // The new head comes from the write port only when the pushed entry lands in the head slot.
    always_comb begin
        w_head = '0;
        if (w_count_nxt != 2'd0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                w_head = w_new;
            end else begin
                w_head = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_oerr   <= 1'b0;
            r_rcreg  <= 32'd0;
            r_rcif   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_new;
            end
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_oerr   <= w_oerr_nxt;
            r_rcreg  <= {{(32-DW){1'b0}}, w_head.dat};
            r_rcif   <= (w_count_nxt != 2'd0);
            r_ferr   <= w_head.ferr;
        end
    end

    assign RCREG    = r_rcreg;
    assign RCIF     = r_rcif;
    assign FERR     = r_ferr;
    assign OERR     = r_oerr;
    assign rx_count = r_count;

endmodule

// File: doc/rcreg_fifo.md
RCREG_FIFO -- requirements
Module: rcreg_fifo

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous and active-low; 0 forces reset state immediately.
REQ-003 SHALL have port: rx_enable  input  1  receiver enable; 0 flushes and holds the FIFO empty.
REQ-004 SHALL have port: rsr_valid  input  1  one-cycle pulse from RSR: a complete frame is present on rsr_data.
REQ-005 SHALL have port: rsr_data  input  8  received data byte from RSR.
REQ-006 SHALL have port: rsr_ferr  input  1  framing error (bad stop bit) for the frame on rsr_data.
REQ-007 SHALL have port: read_enable  input  1  CPU read strobe; pops the head entry.
REQ-008 SHALL have port: clear_oerr  input  1  CPU clear of overrun flag.
REQ-009 SHALL have port: RCREG  output  32  head entry data, zero-extended; 0 when empty.
REQ-010 SHALL have port: RCIF  output  1  receive flag; 1 when FIFO holds at least one entry.
REQ-011 SHALL have port: FERR  output  1  framing-error bit of head entry; 0 when empty.
REQ-012 SHALL have port: OERR  output  1  sticky overrun flag.
REQ-013 SHALL have port: rx_count  output  2  entries held, 0..2.

Function
REQ-014 SHALL implement a 2-entry FIFO of {ferr, data}; one-bit write/read pointers wrapping 1->0.
REQ-015 SHALL push on rsr_valid=1 when rx_enable=1, OERR=0 and the FIFO is not full after any same-cycle pop.
REQ-016 SHALL pop on read_enable=1 when rx_count!=0 at that edge; read_enable while empty SHALL be ignored.
REQ-017 SHALL register all outputs; a push at edge N SHALL make RCIF, RCREG, FERR valid from edge N onward (one-cycle latency from rsr_valid).
REQ-018 SHALL, after a pop, present the next entry on RCREG/FERR from the same edge, or 0 with RCIF=0 if none.
REQ-019 SHALL, on simultaneous push and pop while full, perform both; rx_count stays 2, no OERR.
REQ-020 SHALL, on simultaneous push and pop while empty, perform only the push; rx_count becomes 1.
REQ-021 SHALL, on rsr_valid while full with no same-cycle pop, discard the frame, set OERR=1, and keep both stored entries unchanged.
REQ-022 SHALL ignore rsr_valid while OERR=1; stored entries remain readable via read_enable.
REQ-023 SHALL clear OERR on clear_oerr=1; if rsr_valid is in the same cycle, the frame is dropped and OERR ends at 0.
REQ-024 SHALL, when rx_enable=0 at an edge, empty the FIFO, clear OERR, and ignore rsr_valid and read_enable.
REQ-025 SHALL keep rx_count equal to pushes minus pops, never exceeding 2.

Reset
REQ-026 SHALL, while rst=0, force RCREG=0, RCIF=0, FERR=0, OERR=0, rx_count=0 and both pointers to 0, regardless of clk.
REQ-027 SHALL treat a reset mid-operation as a full flush; frames in flight at deassertion are not captured until the first clk edge with rst=1.

Configuration
REQ-028 SHALL use macro RCREG_NINTH_BIT_EN to select 9-bit reception.
REQ-029 SHALL, with RCREG_NINTH_BIT_EN defined, add input rsr_rx9d (1 bit), store it per entry, and present it on RCREG[8]; RCREG[31:9]=0.
REQ-030 SHALL, without RCREG_NINTH_BIT_EN, omit rsr_rx9d and drive RCREG[31:8]=0.

Verification
REQ-031 SHALL cover single frame: rsr_valid with 0xA5, ferr=0 -> next cycle RCIF=1, RCREG=0x000000A5, rx_count=1; read_enable -> RCIF=0, RCREG=0.
REQ-032 SHALL cover ordering/wrap: push 0x11, 0x22, pop, push 0x33, pop, pop -> RCREG shows 0x11, 0x22, 0x33 in order, then RCIF=0.
REQ-033 SHALL cover overrun: push 0x01, 0x02, then 0x03 with no read -> OERR=1, rx_count=2; reads return 0x01, 0x02; push 0x04 ignored until clear_oerr, then accepted.
REQ-034 SHALL cover simultaneous full push/pop: full with 0x01,0x02; rsr_valid 0x03 with read_enable -> OERR=0, rx_count=2, RCREG=0x02 then 0x03.
REQ-035 SHALL cover framing error and flush: push 0x55 with rsr_ferr=1 -> FERR=1; rx_enable=0 for one cycle -> RCIF=0, FERR=0, rx_count=0.
REQ-036 SHALL cover async reset: with rx_count=2 and OERR=1, drive rst=0 between clk edges -> all outputs 0 immediately.
